nibble_serial_addsub: RTL and testbench
=======================================

# nibble_serial_addsub

Multi-cycle WIDTH-bit add/subtract engine that drives the team's 4-bit ripple adder one nibble per clock. It feeds the adder its operand nibbles and carry-in, and collects each 4-bit sum and carry-out into a result register. It reports carry, overflow and zero flags. It sits between the ALU operand-issue logic and the ALU result mux, and trades latency for adder area.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 8.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  engine can accept a request.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled on accept.
- op_a  in  WIDTH  operand A; sampled on accept.
- op_b  in  WIDTH  operand B; sampled on accept.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- flag_c  out  1  final carry-out. For subtraction, 1 = no borrow.
- flag_v  out  1  signed overflow.
- flag_z  out  1  result == 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch op_a, the effective B (op_b, or ~op_b when op_sub), and op_sub.
  - Set the carry register to op_sub and the nibble index to 0, then go to CALC.
- CALC:
  - in_ready=0.
  - Adder inputs each cycle: A = latched A nibble[idx], B = effective B nibble[idx], Cin = carry register.
  - At the clock edge: write Sum into result nibble[idx] and Cout into the carry register.
  - At idx == WIDTH/4-1, go to DONE; otherwise increment idx.
- DONE:
  - out_valid=1. result, flag_c, flag_v and flag_z stay stable until the handshake.
  - On out_ready, go to IDLE.
  - A request arriving in DONE is not accepted; in_ready stays 0.
- Flags:
  - flag_c = final carry register.
  - flag_v = (A[MSB] == effB[MSB]) && (result[MSB] != A[MSB]).
  - flag_z = ~|result.
  - All flags are computed from registered values and are valid only while out_valid=1.
- Arithmetic: all operations are modulo 2^WIDTH. No saturation and no sign extension.
- Reset: asserting rst_n low at any time, including mid-CALC, does the following:
  - Aborts the operation and sends the FSM to IDLE.
  - Clears result, flags, carry, idx and operand registers to 0.
  - Forces out_valid=0.
  - in_ready goes to 1 once reset deasserts.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, flag_c=0, flag_v=0, flag_z=0.
- Accept edge is E0. CALC occupies the WIDTH/4 cycles after E0; out_valid rises in the cycle after the last CALC edge.
- For WIDTH=16, out_valid is first high 5 cycles after the E0 cycle.
- Minimum issue interval is WIDTH/4+2 cycles, with out_ready held high.
- Backpressure: out_valid and all outputs hold indefinitely while out_ready=0.
- out_valid falls in the cycle after the out_valid && out_ready edge, and in_ready rises in that same cycle.
- in_ready and out_valid are never both 1.
- Inputs are ignored when not accepted. Changing op_a, op_b or op_sub during CALC has no effect.
- The adder path is combinational within one cycle: latched nibbles -> adder -> result and carry registers.

## Structure
- Shared package alu_pkg:
  - typedef of the state enum (IDLE, CALC, DONE).
  - localparam NIBBLE = 4.
  - op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- One sub-module: a single instance of adder_4bit, named u_adder.
- Everything else (FSM, index counter, operand, result and carry registers, flag logic) lives in this module.

## Test plan
- add 0x1234 + 0x4321 -> result 0x5555, c=0, v=0, z=0, out_valid in 5th cycle after accept.
- add 0xFFFF + 0x0001 -> result 0x0000, c=1, v=0, z=1 (carry ripples through all 4 nibbles).
- add 0x7FFF + 0x0001 -> 0x8000, v=1, c=0; sub 0x8000 - 0x0001 -> 0x7FFF, v=1, c=1.
- sub 0x0005 - 0x0007 -> 0xFFFE, c=0 (borrow), v=0; sub 0x0007 - 0x0007 -> 0x0000, z=1, c=1.
- Hold out_ready=0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0, a new in_valid is not accepted. Release -> IDLE next cycle, and the next request is accepted.
- Pulse rst_n low during the 2nd CALC cycle -> all outputs return to reset values immediately. After release, a fresh 0x0001 + 0x0001 yields 0x0002 with no stale carry.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, nibble width, op encoding, flag bundle.
package alu_pkg;

  localparam int unsigned NIBBLE = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } flags_t;

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/response bundle for the nibble-serial add/sub engine.
//   master : operand issuer + result consumer (drives in_valid, op_*, out_ready)
//   slave  : the engine (drives in_ready, out_valid, result, flag_*)
// WIDTH must match the engine's WIDTH parameter.
interface nibble_serial_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;

  modport master (
    output in_valid, op_sub, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z
  );

  modport slave (
    input  in_valid, op_sub, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z
  );

endinterface

// File: rtl/adder_4bit.sv
// 4-bit adder with carry-in/carry-out; purely combinational.
//   a, b   : addend nibbles
//   cin    : carry in
//   sum_c  : 4-bit sum
//   cout_c : carry out
module adder_4bit
  import alu_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum_c,
  output logic              cout_c
);

  logic [NIBBLE:0] total;

  assign total  = (NIBBLE+1)'(a) + (NIBBLE+1)'(b) + (NIBBLE+1)'(cin);
  assign sum_c  = total[NIBBLE-1:0];
  assign cout_c = total[NIBBLE];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract engine: one nibble per clock through a
// single 4-bit adder, least-significant nibble first. Reports carry (no-borrow
// for subtract), signed overflow and zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nibble_serial_addsub_if (request in, result out)
module nibble_serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_addsub_if.slave  bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE;
  localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  if (((WIDTH % NIBBLE) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  flags_t            flags_q, flags_d;
  logic              in_ready_q, out_valid_q;
  logic              accept_c, calc_last_c;
  logic [NIBBLE-1:0] a_nib, b_nib, sum_nib;
  logic              cout;

  // Nibble currently in flight
  assign a_nib = a_q[32'(idx_q) * NIBBLE +: NIBBLE];
  assign b_nib = b_q[32'(idx_q) * NIBBLE +: NIBBLE];

  adder_4bit u_adder (
    .a      (a_nib),
    .b      (b_nib),
    .cin    (carry_q),
    .sum_c  (sum_nib),
    .cout_c (cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    calc_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (idx_q == IDX_LAST) begin
          calc_last_c = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result with this cycle's nibble merged in; flags are taken from it on the
  // last nibble so they are registered in the same edge as the final sum.
  always_comb begin
    result_d = result_q;
    result_d[32'(idx_q) * NIBBLE +: NIBBLE] = sum_nib;
    flags_d.c = cout;
    flags_d.v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
    flags_d.z = ~|result_d;
  end

  // Operand, result, carry, index, flag and handshake registers.
  // op_sub is held as the initial carry (two's-complement +1 on inverted B).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      if (accept_c) begin
        a_q     <= bus.op_a;
        b_q     <= (bus.op_sub == OP_SUB) ? ~bus.op_b : bus.op_b;
        carry_q <= bus.op_sub;
        idx_q   <= '0;
      end else if (state_q == CALC) begin
        result_q <= result_d;
        carry_q  <= cout;
        if (calc_last_c) flags_q <= flags_d;
        else             idx_q   <= idx_q + IDXW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_v    = flags_q.v;
  assign bus.flag_z    = flags_q.z;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: directed corner cases,
// backpressure, mid-operation reset, then random operations against an
// arithmetic reference model.
module tb_nibble_serial_addsub;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  nibble_serial_addsub_if #(.WIDTH(W)) bus ();

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic c, output logic v,
                                output logic z);
    longint sa, sb, s;
    longint ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub == OP_SUB) begin
      s = sa - sb;
      u = ua - ub;
      c = (ua >= ub);
    end else begin
      s = sa + sb;
      u = ua + ub;
      c = (u >= (64'sd1 <<< W));
    end
    r = W'(u);
    v = (s > ((64'sd1 <<< (W-1)) - 1)) || (s < -(64'sd1 <<< (W-1)));
    z = (r == '0);
  endfunction

  // Issue one op from an idle negedge; optionally hold out_ready low for
  // 'hold' cycles after out_valid rises while offering a competing request.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold);
    logic [W-1:0] er;
    logic ec, ev, ez;
    int n;
    model(a, b, sub, er, ec, ev, ez);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_sub    = sub;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    bus.op_sub   = 1'($urandom);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      chk("in_ready_calc", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd5);
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("result", 32'(bus.result), 32'(er));
    chk("flag_c", 32'(bus.flag_c), 32'(ec));
    chk("flag_v", 32'(bus.flag_v), 32'(ev));
    chk("flag_z", 32'(bus.flag_z), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      bus.op_sub   = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_result", 32'(bus.result), 32'(er));
      chk("hold_flags", 32'({bus.flag_c, bus.flag_v, bus.flag_z}), 32'({ec, ev, ez}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_fall", 32'(bus.out_valid), 32'd0);
    chk("in_ready_rise", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sub    = OP_ADD;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.flag_c, bus.flag_v, bus.flag_z}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(16'h1234, 16'h4321, OP_ADD, 0);
    run_op(16'hFFFF, 16'h0001, OP_ADD, 0);
    run_op(16'h7FFF, 16'h0001, OP_ADD, 0);
    run_op(16'h8000, 16'h0001, OP_SUB, 0);
    run_op(16'h0005, 16'h0007, OP_SUB, 0);
    run_op(16'h0007, 16'h0007, OP_SUB, 0);

    // Backpressure for 10 cycles, then an immediate follow-up request
    run_op(16'hABCD, 16'h1234, OP_SUB, 10);
    run_op(16'h0F0F, 16'hF0F1, OP_ADD, 0);

    // Reset pulse during the 2nd CALC cycle
    bus.in_valid = 1'b1;
    bus.op_a     = 16'hFFFF;
    bus.op_b     = 16'h0001;
    bus.op_sub   = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_flags", 32'({bus.flag_c, bus.flag_v, bus.flag_z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0001, 16'h0001, OP_ADD, 0);

    // Random operations, occasional short backpressure
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
